mux_bus_rr_sched: RTL and testbench
===================================

// Module: mux_bus_rr_sched
// PURPOSE
//  Round-robin scheduler that shares a C_WIDTH-bit bus mux between C_INPUTS requesters.
//  It arbitrates the REQ lines and drives the mux select S.
//  It registers the selected word into a single output stage with a valid/ready handshake.
//  Grants are held for a burst, ended by LAST or by the C_MAX_BURST beat limit.
//  It sits in front of the mux/register datapath and owns its select and enable.
// PARAMETERS
//  C_INPUTS     4   number of requesters, 2..32
//  C_SEL_WIDTH  2   select width, = ceil(log2(C_INPUTS))
//  C_WIDTH      8   data word width
//  C_MAX_BURST  4   max beats per grant, 1..255; 0 = unlimited (LAST only)
// PORTS
//  CLK      in   1                   clock, rising edge
//  ACLR_N   in   1                   asynchronous active-low reset
//  REQ      in   C_INPUTS            per-requester request; held while data is offered
//  LAST     in   C_INPUTS            per-requester last-beat flag, qualified by REQ
//  D        in   C_INPUTS*C_WIDTH    requester data, flattened; requester i = D[i*C_WIDTH +: C_WIDTH]
//  GNT      out  C_INPUTS            one-hot grant; a beat moves when GNT[i]&REQ[i]&FREE
//  S        out  C_SEL_WIDTH         index of current/last owner (mux select)
//  Q        out  C_WIDTH             registered output word
//  Q_VALID  out  1                   Q holds an unconsumed beat
//  Q_LAST   out  1                   Q is the final beat of its grant
//  Q_READY  in   1                   downstream accepts Q this cycle
//  BUSY     out  1                   state == GRANT
// BEHAVIOUR
//  Reset (async, immediate): GNT=0, S=0, Q=0, Q_VALID=0, Q_LAST=0, BUSY=0.
//   Reset also clears internals: PTR=0, beat count CNT=0, state=IDLE.
//  FREE = ~Q_VALID | Q_READY (output stage can load this cycle).
//  ACCEPT = GNT[S] & REQ[S] & FREE.
//  State IDLE:
//   - If REQ is nonzero, choose the first set index at or above PTR, cyclic mod C_INPUTS.
//   - Next edge: S<=win, GNT<=onehot(win), CNT<=0, state<=GRANT.
//   - If REQ is zero, stay in IDLE with GNT=0 and S holding its value.
//  State GRANT, first matching rule wins:
//   - ACCEPT: Q<=D[S], Q_VALID<=1, Q_LAST<=END, CNT<=CNT+1.
//     END = LAST[S] | (C_MAX_BURST!=0 & CNT+1==C_MAX_BURST).
//     If END: GNT<=0, PTR<=(S+1) mod C_INPUTS, state<=IDLE.
//   - ~REQ[S] (owner abandons, no accept): GNT<=0, PTR<=(S+1) mod C_INPUTS, state<=IDLE.
//     Q is not modified.
//   - Otherwise (backpressure): hold everything.
//  Output stage:
//   - If Q_VALID&Q_READY and no ACCEPT: Q_VALID<=0, Q_LAST<=0; Q keeps its last value.
//   - If Q_READY and ACCEPT occur together, Q is reloaded and Q_VALID stays 1 (no bubble).
//  Latency:
//   - REQ rising in IDLE -> GNT after 1 edge.
//   - Accepted beat -> Q_VALID on the next edge.
//   - End of grant -> one IDLE cycle, then the next grant (at least 1 dead cycle between owners).
//  Fairness:
//   - PTR advances only on release, so an owner cannot be re-granted while others wait.
//   - Maximum wait = (C_INPUTS-1) bursts.
//  S never changes while BUSY=1, so the mux select is stable for the whole burst.
//  CNT is wide enough for 255 and saturates only via END; with C_MAX_BURST=0, CNT may wrap harmlessly.
//  REQ/LAST bits of non-owners are ignored during GRANT.
// TESTING
//  1. ACLR_N low mid-burst (GNT=0100, Q_VALID=1) -> same cycle: GNT=0, Q_VALID=0, S=0, BUSY=0.
//     After release, REQ=0100 -> grant 2 after 1 edge.
//  2. From reset, REQ=1010 held, 1-beat LAST bursts, Q_READY=1 -> grant order 1,3,1,3.
//     Q_VALID pulses one cycle after each GNT cycle.
//  3. C_MAX_BURST=4, REQ=0001 for 6 beats with no LAST -> 4 beats, 4th has Q_LAST=1, 1 idle cycle.
//     Then re-grant 0 and deliver 2 beats.
//  4. Q_READY=0 with Q_VALID=1 during grant 2 -> GNT stays 0100, no ACCEPT, Q stable.
//     Q_READY=1 -> consume and load in the same cycle, Q_VALID stays 1.
//  5. Owner 1 drops REQ after 1 beat (no LAST) -> GNT=0 next edge, PTR=2.
//     Pending REQ=0011 -> grant 0 after the wrap.
//  6. Wrap: last owner 3 (C_INPUTS=4), REQ=1001 -> grant 0, then 3.
//     D[0]=8'hA5 appears on Q with Q_VALID=1 one edge after ACCEPT.

Source files
------------

// File: rtl/mux_bus_rr_sched.sv
// Round-robin scheduler for a shared bus mux: arbitrates REQ, owns the mux select,
// holds grants for a burst and registers the chosen word into one valid/ready stage.

module mux_bus_rr_lane #(
  parameter int IDX = 0,
  parameter int SW  = 2
) (
  input  logic [SW-1:0] ptr_i,
  input  logic          req_i,
  output logic          hi_o
);
  localparam logic [SW-1:0] IDX_L = SW'(IDX);
  // Requester sits in the "at or above PTR" half of the rotation.
  assign hi_o = req_i & (IDX_L >= ptr_i);
endmodule

module mux_bus_rr_sched #(
  parameter int C_INPUTS    = 4,
  parameter int C_SEL_WIDTH = 2,
  parameter int C_WIDTH     = 8,
  parameter int C_MAX_BURST = 4
) (
  input  logic                        CLK,
  input  logic                        ACLR_N,
  input  logic [C_INPUTS-1:0]         REQ,
  input  logic [C_INPUTS-1:0]         LAST,
  input  logic [C_INPUTS*C_WIDTH-1:0] D,
  output logic [C_INPUTS-1:0]         GNT,
  output logic [C_SEL_WIDTH-1:0]      S,
  output logic [C_WIDTH-1:0]          Q,
  output logic                        Q_VALID,
  output logic                        Q_LAST,
  input  logic                        Q_READY,
  output logic                        BUSY
);
  localparam int         NP   = 1 << C_SEL_WIDTH;
  localparam logic [7:0] MAXB = 8'(C_MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [C_SEL_WIDTH-1:0] ptr_q, ptr_d, s_q, s_d, win, s_inc;
  logic [7:0]             cnt_q, cnt_d;
  logic [C_INPUTS-1:0]    gnt_q, gnt_d, hi;
  logic [C_WIDTH-1:0]     q_q, q_d;
  logic                   qv_q, qv_d, ql_q, ql_d;
  logic [NP-1:0]          req_p, last_p, gnt_p;
  logic [C_WIDTH-1:0]     d_arr [NP];
  logic                   free, accept, end_beat, found_hi, found_any;

  // Padding to a power of two keeps select-indexed lookups in range.
  assign req_p  = NP'(REQ);
  assign last_p = NP'(LAST);
  assign gnt_p  = NP'(gnt_q);

  for (genvar g = 0; g < NP; g++) begin : g_lane
    if (g < C_INPUTS) begin : g_used
      assign d_arr[g] = D[g*C_WIDTH +: C_WIDTH];
      mux_bus_rr_lane #(.IDX(g), .SW(C_SEL_WIDTH)) u_lane (
        .ptr_i (ptr_q),
        .req_i (REQ[g]),
        .hi_o  (hi[g])
      );
    end else begin : g_pad
      assign d_arr[g] = '0;
    end
  end

  // Lowest requester at/above PTR, else lowest overall: cyclic search from PTR.
  always_comb begin
    win       = '0;
    found_hi  = 1'b0;
    found_any = 1'b0;
    for (int i = 0; i < C_INPUTS; i++) begin
      if (hi[i] && !found_hi) begin
        win      = C_SEL_WIDTH'(i);
        found_hi = 1'b1;
      end
    end
    if (!found_hi) begin
      for (int i = 0; i < C_INPUTS; i++) begin
        if (REQ[i] && !found_any) begin
          win       = C_SEL_WIDTH'(i);
          found_any = 1'b1;
        end
      end
    end
  end

  assign s_inc    = (s_q == C_SEL_WIDTH'(C_INPUTS-1)) ? '0 : s_q + C_SEL_WIDTH'(1);
  assign free     = ~qv_q | Q_READY;
  assign accept   = (state_q == GRANT) & gnt_p[s_q] & req_p[s_q] & free;
  assign end_beat = last_p[s_q] | ((MAXB != 8'd0) && (cnt_q + 8'd1 == MAXB));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    qv_d    = qv_q;
    ql_d    = ql_q;

    if (accept) begin
      q_d  = d_arr[s_q];
      qv_d = 1'b1;
      ql_d = end_beat;
    end else if (qv_q && Q_READY) begin
      qv_d = 1'b0;
      ql_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|REQ) begin
          s_d     = win;
          gnt_d   = C_INPUTS'(1) << win;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (end_beat) begin
            gnt_d   = '0;
            ptr_d   = s_inc;
            state_d = IDLE;
          end
        end else if (!req_p[s_q]) begin
          // Owner walked away mid-burst; release without touching Q.
          gnt_d   = '0;
          ptr_d   = s_inc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      s_q     <= '0;
      cnt_q   <= 8'd0;
      gnt_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ql_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ql_q    <= ql_d;
    end
  end

  assign GNT     = gnt_q;
  assign S       = s_q;
  assign Q       = q_q;
  assign Q_VALID = qv_q;
  assign Q_LAST  = ql_q;
  assign BUSY    = (state_q == GRANT);
endmodule

// File: tb/tb_mux_bus_rr_sched.sv
// Bench for mux_bus_rr_sched: directed scenarios plus random traffic, all checked
// against a cycle-level ownership model of the scheduler.

module tb_mux_bus_rr_sched;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int W  = 8;
  localparam int MB = 4;

  logic            CLK = 1'b0;
  logic            ACLR_N;
  logic [N-1:0]    REQ, LAST;
  logic [N*W-1:0]  D;
  logic            Q_READY;
  logic [N-1:0]    GNT;
  logic [SW-1:0]   S;
  logic [W-1:0]    Q;
  logic            Q_VALID, Q_LAST, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, beats taken, and the output slot.
  bit       m_busy, m_qv, m_ql;
  int       m_ptr, m_s, m_cnt;
  logic [W-1:0] m_q;

  mux_bus_rr_sched #(.C_INPUTS(N), .C_SEL_WIDTH(SW), .C_WIDTH(W), .C_MAX_BURST(MB)) dut (
    .CLK(CLK), .ACLR_N(ACLR_N), .REQ(REQ), .LAST(LAST), .D(D),
    .GNT(GNT), .S(S), .Q(Q), .Q_VALID(Q_VALID), .Q_LAST(Q_LAST),
    .Q_READY(Q_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N-1:0] m_gnt();
    return m_busy ? N'(1 << m_s) : '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_qv = 0; m_ql = 0;
    m_ptr = 0; m_s = 0; m_cnt = 0; m_q = '0;
  endtask

  task automatic model_step();
    bit free, found;
    free  = !m_qv || Q_READY;
    found = 0;
    if (!m_busy) begin
      if (m_qv && Q_READY) begin m_qv = 0; m_ql = 0; end
      if (REQ != '0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && REQ[(m_ptr + k) % N]) begin
            m_s = (m_ptr + k) % N;
            found = 1;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (REQ[m_s] && free) begin
      m_q  = D[m_s*W +: W];
      m_qv = 1;
      m_cnt++;
      m_ql = LAST[m_s] || (MB != 0 && m_cnt == MB);
      if (m_ql) begin m_busy = 0; m_ptr = (m_s + 1) % N; end
    end else begin
      if (m_qv && Q_READY) begin m_qv = 0; m_ql = 0; end
      if (!REQ[m_s]) begin m_busy = 0; m_ptr = (m_s + 1) % N; end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    ACLR_N = 1'b0; REQ = '0; LAST = '0; D = '0; Q_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    ACLR_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({GNT, S, Q, Q_VALID, Q_LAST, BUSY} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b s=%0d q=%h v=%b l=%b busy=%b, want all 0",
               GNT, S, Q, Q_VALID, Q_LAST, BUSY);
    end
    REQ = 4'b0100; D = $urandom;
    tick(); tick();
    n_checks++;
    if (GNT !== 4'b0100 || Q_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup: got gnt=%b v=%b, want gnt=0100 v=1", GNT, Q_VALID);
    end
    #2 ACLR_N = 1'b0;
    #1;
    n_checks++;
    if (GNT !== 4'b0000 || Q_VALID !== 1'b0 || S !== 2'd0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got gnt=%b v=%b s=%0d busy=%b, want 0000 0 0 0",
               GNT, Q_VALID, S, BUSY);
    end
    model_reset();
    @(negedge CLK);
    ACLR_N = 1'b1;
    REQ = 4'b0100;
    tick();
    n_checks++;
    if (GNT !== 4'b0100 || S !== 2'd2 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_regrant: got gnt=%b s=%0d busy=%b, want 0100 2 1", GNT, S, BUSY);
    end
  endtask

  task automatic test_alternate();
    int order[$];
    bit prev_g;
    do_reset();
    REQ = 4'b1010; LAST = 4'b1111; Q_READY = 1'b1;
    prev_g = 0;
    for (int c = 0; c < 8; c++) begin
      D = $urandom;
      tick();
      n_checks++;
      if ({GNT, S, Q, Q_VALID, Q_LAST, BUSY} !== {m_gnt(), SW'(m_s), m_q, m_qv, m_ql, m_busy}) begin
        n_fail++;
        $display("FAIL alt_model c%0d: got gnt=%b s=%0d q=%h v=%b l=%b b=%b, want gnt=%b s=%0d q=%h v=%b l=%b b=%b",
                 c, GNT, S, Q, Q_VALID, Q_LAST, BUSY, m_gnt(), m_s, m_q, m_qv, m_ql, m_busy);
      end
      n_checks++;
      if (Q_VALID !== prev_g) begin
        n_fail++;
        $display("FAIL alt_qv_pulse c%0d: got v=%b, want %b", c, Q_VALID, prev_g);
      end
      prev_g = (GNT != '0);
      for (int b = 0; b < N; b++) if (GNT[b]) order.push_back(b);
    end
    n_checks++;
    if (order.size() != 4 || order[0] != 1 || order[1] != 3 || order[2] != 1 || order[3] != 3) begin
      n_fail++;
      $display("FAIL alt_order: got %p, want 1 3 1 3", order);
    end
  endtask

  task automatic test_max_burst();
    int beats;
    do_reset();
    REQ = 4'b0001; LAST = '0; Q_READY = 1'b1;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      D = $urandom;
      tick();
      if (Q_VALID) beats++;
      n_checks++;
      if ({GNT, S, Q, Q_VALID, Q_LAST, BUSY} !== {m_gnt(), SW'(m_s), m_q, m_qv, m_ql, m_busy}) begin
        n_fail++;
        $display("FAIL burst_model c%0d: got gnt=%b q=%h v=%b l=%b, want gnt=%b q=%h v=%b l=%b",
                 c, GNT, Q, Q_VALID, Q_LAST, m_gnt(), m_q, m_qv, m_ql);
      end
      if (c == 4) begin
        n_checks++;
        if (Q_LAST !== 1'b1 || GNT !== 4'b0000 || Q_VALID !== 1'b1) begin
          n_fail++;
          $display("FAIL burst_end: got l=%b gnt=%b v=%b, want 1 0000 1", Q_LAST, GNT, Q_VALID);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (GNT !== 4'b0001 || Q_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_regrant: got gnt=%b v=%b, want 0001 0", GNT, Q_VALID);
        end
      end
    end
    n_checks++;
    if (beats != 6) begin
      n_fail++;
      $display("FAIL burst_beats: got %0d, want 6", beats);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    logic [N*W-1:0] nd;
    do_reset();
    REQ = 4'b0100; Q_READY = 1'b0; D = $urandom;
    tick(); tick();
    held = Q;
    for (int c = 0; c < 3; c++) begin
      D = $urandom;
      tick();
      n_checks++;
      if (GNT !== 4'b0100 || Q !== held || Q_VALID !== 1'b1 || Q !== m_q) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got gnt=%b q=%h v=%b, want 0100 %h 1", c, GNT, Q, Q_VALID, held);
      end
    end
    nd = $urandom;
    D = nd; Q_READY = 1'b1;
    tick();
    n_checks++;
    if (Q !== nd[2*W +: W] || Q_VALID !== 1'b1 || Q_LAST !== 1'b0 || GNT !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_reload: got q=%h v=%b l=%b gnt=%b, want %h 1 0 0100",
               Q, Q_VALID, Q_LAST, GNT, nd[2*W +: W]);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    REQ = 4'b0010; LAST = '0; Q_READY = 1'b1; D = $urandom;
    tick();
    n_checks++;
    if (GNT !== 4'b0010) begin
      n_fail++;
      $display("FAIL abandon_grant: got gnt=%b, want 0010", GNT);
    end
    tick();
    REQ = 4'b0000;
    tick();
    n_checks++;
    if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL abandon_release: got gnt=%b busy=%b, want 0000 0", GNT, BUSY);
    end
    REQ = 4'b0011;
    tick();
    n_checks++;
    if (GNT !== 4'b0001 || S !== 2'd0) begin
      n_fail++;
      $display("FAIL abandon_wrap: got gnt=%b s=%0d, want 0001 0", GNT, S);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    REQ = 4'b1000; LAST = 4'b1000; Q_READY = 1'b1; D = $urandom;
    tick(); tick();
    REQ = 4'b1001; LAST = 4'b1001;
    D = ($urandom & 32'hFFFF_FF00) | 32'h0000_00A5;
    tick();
    n_checks++;
    if (GNT !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_grant0: got gnt=%b, want 0001", GNT);
    end
    tick();
    n_checks++;
    if (Q !== 8'hA5 || Q_VALID !== 1'b1 || Q_LAST !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_data: got q=%h v=%b l=%b, want a5 1 1", Q, Q_VALID, Q_LAST);
    end
    tick();
    n_checks++;
    if (GNT !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_grant3: got gnt=%b, want 1000", GNT);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      REQ     = REQ ^ N'($urandom & $urandom);
      LAST    = N'($urandom & $urandom);
      Q_READY = ($urandom_range(0, 2) != 0);
      D       = $urandom;
      tick();
      n_checks++;
      if ({GNT, S, Q, Q_VALID, Q_LAST, BUSY} !== {m_gnt(), SW'(m_s), m_q, m_qv, m_ql, m_busy}) begin
        n_fail++;
        $display("FAIL rand_c%0d: got gnt=%b s=%0d q=%h v=%b l=%b b=%b, want gnt=%b s=%0d q=%h v=%b l=%b b=%b",
                 c, GNT, S, Q, Q_VALID, Q_LAST, BUSY, m_gnt(), m_s, m_q, m_qv, m_ql, m_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alternate();
    test_max_burst();
    test_backpressure();
    test_abandon();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
